instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Instruction sequencer that drives the control unit's inputs: holds the PC, fetches 16-bit instruction words from program memory over a req/ack handshake, and presents them to decode with a valid/ready handshake.
- Consumes the decode result (s_inc) to choose the next PC: increment, or load the jump target embedded in the instruction.
- Sits between program memory and the control unit / datapath.

Parameters:
- PC_W, 10, PC and memory address width.
- INSTR_W, 16, instruction word width.
- OPC_W, 6, opcode width; opcode = instr[INSTR_W-1 -: OPC_W].
- TIMEOUT, 15, maximum cycles mem_req is held without mem_ack before a retry; must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, synchronous, active-high.
- mem_req  out  1  fetch request to program memory.
- mem_addr  out  PC_W  fetch address; equals pc; stable while mem_req=1.
- mem_ack  in  1  single-cycle acknowledge; mem_rdata valid in the same cycle.
- mem_rdata  in  INSTR_W  instruction word from memory.
- instr_valid  out  1  instr/opcode hold a fetched instruction.
- instr_ready  in  1  decode/datapath consumes the instruction this cycle.
- instr  out  INSTR_W  fetched instruction register.
- opcode  out  OPC_W  top OPC_W bits of instr (combinational slice).
- s_inc  in  1  from control unit: 1 = next PC is pc+1; 0 = next PC is jump target instr[PC_W-1:0].
- pc  out  PC_W  address of the current instruction.
- bus_err  out  1  one-cycle pulse when a fetch times out.

Behaviour:
- States: START, FETCH, VALID, RETRY.
- Reset (sync, takes priority over every other event, including mid-fetch):
  - state=START; pc=0; instr=0; instr_valid=0; mem_req=0; bus_err=0; timeout counter=0.
- START: mem_req=0 for exactly one cycle, then go to FETCH. Any mem_ack seen in START is ignored; this discards stale acks from a fetch aborted by reset.
- FETCH:
  - mem_req=1, mem_addr=pc. mem_req is registered and is high from the first FETCH cycle.
  - mem_ack sampled high: instr <= mem_rdata; go to VALID; instr_valid=1 from the next cycle.
  - Ack may arrive in the first FETCH cycle, giving minimum fetch latency 1 cycle.
  - Counter counts cycles in FETCH without ack. When it reaches TIMEOUT with no ack: go to RETRY; bus_err pulses 1 cycle; counter clears.
- RETRY: mem_req=0 for one cycle; any ack there is ignored; return to FETCH at the same pc.
- VALID:
  - instr_valid=1; instr and pc held stable; mem_req=0.
  - On instr_valid && instr_ready: s_inc is sampled this same cycle; pc <= s_inc ? pc+1 : instr[PC_W-1:0]; instr_valid <= 0; go to FETCH.
  - Without ready: hold indefinitely.
  - Peak throughput is 1 instruction per 2 cycles.
- Arithmetic: pc+1 is modulo 2^PC_W; all-ones wraps to 0 with no flag. A jump to the current pc (self-loop) is legal and refetches.
- instr_ready while instr_valid=0: ignored; pc unchanged.
- mem_ack outside FETCH: ignored, with no state change.
- opcode always equals instr[INSTR_W-1:INSTR_W-OPC_W], so it reads 0 after reset.

Test Plan:
- Reset, mem acks after 1 cycle with rdata=16'h0400, instr_ready=1, s_inc=1:
  - mem_addr sequence 0,1,2,…; opcode=6'b000001 while instr_valid=1.
  - One instruction every 2 cycles.
- pc=5, instr=16'hFC2A (opcode 6'b111111), s_inc=0, ready=1 → next mem_addr=10'h02A; instr_valid drops for at least 1 cycle.
- pc=10'h3FF, s_inc=1, consume → pc wraps to 0; next mem_addr=0.
- instr_ready held 0 for 8 cycles in VALID → instr, pc and instr_valid stable; mem_req=0; no ack taken. Ready=1 → advance exactly once.
- Memory never acks at pc=3 → after 15 FETCH cycles:
  - bus_err pulses once; mem_req low 1 cycle, then high again at addr 3.
  - Ack on the retry → normal VALID.
- Reset asserted mid-FETCH at pc=7, mem_ack arriving in the START cycle → ack ignored; pc=0; instr=0; first request at addr 0 one cycle after START.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: owns the PC, fetches words from program memory
// over req/ack, and hands them to decode over valid/ready.
module instr_fetch_unit #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 16,
  parameter int OPC_W   = 6,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [OPC_W-1:0]   opcode,
  input  logic               s_inc,
  output logic [PC_W-1:0]    pc,
  output logic               bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    RETRY = 2'd3
  } state_t;

  state_t             state_r;
  logic [PC_W-1:0]    pc_r;
  logic [INSTR_W-1:0] instr_r;
  logic               instr_valid_r;
  logic               mem_req_r;
  logic               bus_err_r;
  logic [CNT_W-1:0]   tcnt_r;
  logic [PC_W-1:0]    next_pc_s;

  assign mem_req     = mem_req_r;
  assign mem_addr    = pc_r;
  assign instr_valid = instr_valid_r;
  assign instr       = instr_r;
  assign opcode      = instr_r[INSTR_W-1 -: OPC_W];
  assign pc          = pc_r;
  assign bus_err     = bus_err_r;

  // Next PC: sequential increment (wraps silently) or the jump target in the low bits.
  always_comb begin
    next_pc_s = pc_r;
    if (s_inc) begin
      next_pc_s = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
    end else begin
      next_pc_s = instr_r[PC_W-1:0];
    end
  end

  // Fetch sequencer; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= START;
      pc_r          <= {PC_W{1'b0}};
      instr_r       <= {INSTR_W{1'b0}};
      instr_valid_r <= 1'b0;
      mem_req_r     <= 1'b0;
      bus_err_r     <= 1'b0;
      tcnt_r        <= {CNT_W{1'b0}};
    end else begin
      bus_err_r <= 1'b0;
      case (state_r)
        // One idle cycle drops any ack left over from a fetch cut short by reset.
        START: begin
          mem_req_r <= 1'b1;
          tcnt_r    <= {CNT_W{1'b0}};
          state_r   <= FETCH;
        end
        FETCH: begin
          if (mem_ack) begin
            instr_r       <= mem_rdata;
            instr_valid_r <= 1'b1;
            mem_req_r     <= 1'b0;
            tcnt_r        <= {CNT_W{1'b0}};
            state_r       <= VALID;
          end else if (tcnt_r == CNT_W'(TIMEOUT - 1)) begin
            mem_req_r <= 1'b0;
            bus_err_r <= 1'b1;
            tcnt_r    <= {CNT_W{1'b0}};
            state_r   <= RETRY;
          end else begin
            tcnt_r <= tcnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        RETRY: begin
          mem_req_r <= 1'b1;
          state_r   <= FETCH;
        end
        VALID: begin
          if (instr_ready) begin
            pc_r          <= next_pc_s;
            instr_valid_r <= 1'b0;
            mem_req_r     <= 1'b1;
            state_r       <= FETCH;
          end else begin
            state_r <= VALID;
          end
        end
        default: begin
          state_r       <= START;
          instr_valid_r <= 1'b0;
          mem_req_r     <= 1'b0;
          tcnt_r        <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a memory/decode model drives the DUT,
// expected fetch addresses and consumed instructions are queued and popped by a monitor.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [9:0]  mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [5:0]  opcode;
  logic        s_inc;
  logic [9:0]  pc;
  logic        bus_err;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .opcode(opcode), .s_inc(s_inc),
    .pc(pc), .bus_err(bus_err)
  );

  typedef struct {
    logic [9:0]  pc;
    logic [15:0] ins;
    logic [5:0]  opc;
  } cons_t;

  logic [9:0]  exp_fetch[$];
  cons_t       exp_cons[$];
  logic [15:0] rom[0:1023];
  logic        inc_map[0:1023];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_cons = 0;
  int n_buserr = 0;
  int cons_cyc[0:31];

  logic        ready_en = 1'b1;
  logic [9:0]  stall_pc = 10'h3FF;
  logic        block_active = 1'b0;
  logic [9:0]  block_addr = 10'd0;
  logic        force_ack = 1'b0;
  logic [15:0] force_rdata = 16'h0000;
  logic        model_ack = 1'b0;
  logic [15:0] model_rdata = 16'h0000;

  assign mem_ack   = force_ack | model_ack;
  assign mem_rdata = force_ack ? force_rdata : model_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_cons(input logic [9:0] p, input logic [15:0] i, input logic [5:0] o);
    cons_t c;
    c.pc = p; c.ins = i; c.opc = o;
    exp_cons.push_back(c);
  endtask

  // Memory and decode model: responds 1 cycle after a request, drives ready / s_inc.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      model_ack   = mem_req && !(block_active && (mem_addr == block_addr));
      model_rdata = model_ack ? rom[mem_addr] : 16'h0000;
      instr_ready = ready_en && (pc != stall_pc);
      s_inc       = inc_map[pc];
    end
  end

  // Monitor: pops expectations whenever a fetch is accepted or an instruction consumed.
  initial begin
    logic [9:0] ea;
    cons_t      ec;
    logic       just_cons;
    just_cons = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (just_cons) chk("valid_drop", {31'd0, instr_valid}, 32'd0);
      just_cons = 1'b0;
      if (mem_req && mem_ack) begin
        if (exp_fetch.size() == 0) begin
          total++; bad++;
          $display("FAIL fetch_extra: got addr %0h expected none", mem_addr);
        end else begin
          ea = exp_fetch.pop_front();
          chk("fetch_addr", {22'd0, mem_addr}, {22'd0, ea});
        end
      end
      if (instr_valid && instr_ready) begin
        if (exp_cons.size() == 0) begin
          total++; bad++;
          $display("FAIL consume_extra: got pc %0h expected none", pc);
        end else begin
          ec = exp_cons.pop_front();
          chk("cons_pc", {22'd0, pc}, {22'd0, ec.pc});
          chk("cons_instr", {16'd0, instr}, {16'd0, ec.ins});
          chk("cons_opcode", {26'd0, opcode}, {26'd0, ec.opc});
        end
        if (n_cons < 32) cons_cyc[n_cons] = cyc;
        n_cons++;
        just_cons = 1'b1;
      end
      if (bus_err) n_buserr++;
    end
  end

  // Directed stimulus and phase checks.
  initial begin
    int guard;
    int fcnt;
    logic [9:0] fa[0:16];

    for (int i = 0; i < 1024; i++) begin
      rom[i] = 16'h0400;
      inc_map[i] = 1'b1;
    end
    rom[5]       = 16'hFC2A;
    rom[10'h02A] = 16'h0BFF;
    rom[10'h3FF] = 16'h1234;
    inc_map[5]       = 1'b0;
    inc_map[10'h02A] = 1'b0;

    fa = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'h02A, 10'h3FF,
           10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd0, 10'd1};
    for (int i = 0; i < 17; i++) exp_fetch.push_back(fa[i]);
    for (int i = 0; i < 5; i++) push_cons(10'(i), 16'h0400, 6'h01);
    push_cons(10'd5, 16'hFC2A, 6'h3F);
    push_cons(10'h02A, 16'h0BFF, 6'h02);
    push_cons(10'h3FF, 16'h1234, 6'h04);
    for (int i = 0; i < 5; i++) push_cons(10'(i), 16'h0400, 6'h01);
    push_cons(10'd5, 16'hFC2A, 6'h3F);
    push_cons(10'd6, 16'h0400, 6'h01);
    push_cons(10'd0, 16'h0400, 6'h01);

    reset = 1'b1;
    instr_ready = 1'b0;
    s_inc = 1'b1;
    tick(); tick(); tick();
    chk("rst_pc", {22'd0, pc}, 32'd0);
    chk("rst_instr", {16'd0, instr}, 32'd0);
    chk("rst_opcode", {26'd0, opcode}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_buserr", {31'd0, bus_err}, 32'd0);
    reset = 1'b0;

    guard = 0;
    while (n_cons < 5 && guard < 200) begin tick(); guard++; end
    chk("reach_seq", {31'd0, guard < 200}, 32'd1);
    chk("throughput", cons_cyc[4] - cons_cyc[0], 32'd8);

    // Decode stalls on pc 3FF; a stray ack is presented while stalled.
    guard = 0;
    while (!(instr_valid && pc == 10'h3FF) && guard < 200) begin tick(); guard++; end
    chk("reach_stall", {31'd0, guard < 200}, 32'd1);
    force_rdata = 16'hDEAD;
    force_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_instr", {16'd0, instr}, 32'h1234);
      chk("stall_pc", {22'd0, pc}, 32'h3FF);
      chk("stall_req", {31'd0, mem_req}, 32'd0);
    end
    force_ack = 1'b0;
    stall_pc = 10'h155;
    block_addr = 10'd3;
    block_active = 1'b1;

    // Memory never acks at pc 3: expect timeout, one bus_err pulse, retry.
    fcnt = 0;
    guard = 0;
    while (!bus_err && guard < 400) begin
      tick();
      if (mem_req && mem_addr == 10'd3) fcnt++;
      guard++;
    end
    chk("reach_buserr", {31'd0, guard < 400}, 32'd1);
    chk("timeout_cycles", fcnt, 32'd15);
    chk("retry_req_low", {31'd0, mem_req}, 32'd0);
    block_active = 1'b0;
    inc_map[5] = 1'b1;
    tick();
    chk("retry_req_high", {31'd0, mem_req}, 32'd1);
    chk("retry_addr", {22'd0, mem_addr}, 32'd3);
    chk("buserr_pulse", {31'd0, bus_err}, 32'd0);

    // Reset in the middle of a fetch at pc 7, with an ack landing in START.
    block_addr = 10'd7;
    block_active = 1'b1;
    guard = 0;
    while (!(mem_req && mem_addr == 10'd7) && guard < 200) begin tick(); guard++; end
    chk("reach_pc7", {31'd0, guard < 200}, 32'd1);
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_pc", {22'd0, pc}, 32'd0);
    chk("mid_rst_instr", {16'd0, instr}, 32'd0);
    chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
    chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    reset = 1'b0;
    block_active = 1'b0;
    force_rdata = 16'hBEEF;
    force_ack = 1'b1;
    @(posedge clk);
    #1;
    force_ack = 1'b0;
    tick();
    chk("start_req", {31'd0, mem_req}, 32'd1);
    chk("start_addr", {22'd0, mem_addr}, 32'd0);
    chk("start_ack_ignored", {16'd0, instr}, 32'd0);

    guard = 0;
    while (n_cons < 16 && guard < 200) begin tick(); guard++; end
    chk("reach_end", {31'd0, guard < 200}, 32'd1);
    ready_en = 1'b0;
    tick(); tick(); tick(); tick();
    chk("end_valid", {31'd0, instr_valid}, 32'd1);
    chk("end_pc", {22'd0, pc}, 32'd1);
    chk("fetch_q_empty", exp_fetch.size(), 32'd0);
    chk("cons_q_empty", exp_cons.size(), 32'd0);
    chk("buserr_count", n_buserr, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
